// File: rtl/ser_tx_ctrl.sv
// Serial transmit controller: frames each byte as start bit, 8 data bits LSB first and stop bit,
// and steers a downstream parallel-load/shift-right register that has no hold mode of its own.
module ser_tx_ctrl #(
  parameter int BIT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] sr_q,
  output logic [7:0] sr_p_in,
  output logic       sr_load,
  output logic       sr_s_in,
  output logic       ser_out,
  output logic       busy,
  output logic       tx_done
);

  localparam int               DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             tx_done_q, tx_done_d;
  logic             div_last_s;

  assign div_last_s = (div_cnt_q == DIV_LAST);
  assign tx_done    = tx_done_q;

  // State, bit-time and bit counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_cnt_q <= DIV_ZERO;
      bit_cnt_q <= 3'd0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Frame sequencing
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d   = START;
          div_cnt_d = DIV_ZERO;
        end else begin
          state_d   = IDLE;
        end
      end
      START: begin
        if (div_last_s) begin
          state_d   = DATA;
          div_cnt_d = DIV_ZERO;
          bit_cnt_d = 3'd0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
      end
      DATA: begin
        if (div_last_s) begin
          div_cnt_d = DIV_ZERO;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
      end
      STOP: begin
        if (div_last_s) begin
          state_d   = IDLE;
          div_cnt_d = DIV_ZERO;
          tx_done_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = DIV_ZERO;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // Line and register steering; holding means reloading the register with its own Q
  always_comb begin
    tx_ready = 1'b0;
    busy     = 1'b1;
    ser_out  = 1'b1;
    sr_load  = 1'b1;
    sr_p_in  = sr_q;
    sr_s_in  = 1'b1;
    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        sr_p_in  = tx_data;
        sr_load  = tx_valid;
      end
      START: begin
        ser_out = 1'b0;
      end
      DATA: begin
        ser_out = sr_q[0];
        sr_load = !div_last_s;
      end
      STOP: begin
        sr_load = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/ser_tx_ctrl.md
Name: ser_tx_ctrl

Overview:
- Byte-level serial transmit controller that drives the 8-bit parallel-load/shift-right register one stage downstream.
- Accepts bytes over a valid/ready handshake and emits an idle-high serial frame: start bit 0, 8 data bits LSB first, stop bit 1.
- Sequences the register's load/shift select (S) and serial fill input.
- The register has no hold mode: with S=0 it shifts on every clock. This block holds its contents by reloading the register's own output.

Parameters:
- BIT_DIV, 4, clock cycles per serial bit. Legal range 1..256.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send; sampled only in the accept cycle
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller can accept a byte (high in IDLE only)
- sr_q  in  8  register Q[7:0]
- sr_p_in  out  8  register parallel input
- sr_load  out  1  register S (1 = parallel load, 0 = shift right)
- sr_s_in  out  1  register serial fill; constant 1
- ser_out  out  1  serial line
- busy  out  1  state != IDLE
- tx_done  out  1  registered one-cycle pulse at frame end

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, div_cnt=0, bit_cnt=0, tx_done=0.
  - Outputs during reset: ser_out=1, tx_ready=1, busy=0.
  - The register is not reset; it is reloaded at accept.
- States IDLE, START, DATA, STOP:
  - IDLE: tx_ready=1; sr_p_in=tx_data; sr_load=tx_valid. Accept = tx_valid & tx_ready. On accept the register captures tx_data at that edge and state -> START with div_cnt=0.
  - START: ser_out=0; sr_load=1, sr_p_in=sr_q (hold). Lasts BIT_DIV cycles, then -> DATA with bit_cnt=0, div_cnt=0.
  - DATA: ser_out=sr_q[0]. sr_load=0 only when div_cnt==BIT_DIV-1 (shift, fill 1); otherwise sr_load=1 with sr_p_in=sr_q (hold). After bit_cnt==7 with div_cnt==BIT_DIV-1 -> STOP.
  - STOP: ser_out=1; sr_load=0 (register contents are don't-care). Lasts BIT_DIV cycles, then -> IDLE with tx_done=1 for exactly the first IDLE cycle.
- Timing:
  - ser_out is decoded from state and sr_q[0]; it may glitch and is not used as a clock.
  - div_cnt wraps 0..BIT_DIV-1. bit_cnt is 3 bits; it increments on each div_cnt wrap in DATA.
  - Frame = 10*BIT_DIV cycles, starting the cycle after accept.
  - Back-to-back: an accept is legal in the same cycle tx_done=1, so the minimum spacing between accepts is 10*BIT_DIV+1 cycles.
  - BIT_DIV=1: hold is never asserted in DATA; the register shifts every cycle.
- Boundary cases:
  - tx_valid while busy: ignored, tx_ready=0, no data loss obligation.
  - tx_data changes after accept: no effect.
  - rst_n low mid-frame: ser_out=1 immediately. After release the controller is in IDLE and a new byte is accepted normally. The partial frame is never resumed and tx_done is not pulsed.

Test Plan:
- Bench models the register: at posedge, Q<=S ? p_in : {s_in,Q[7:1]}.
- BIT_DIV=4, send 0xA5:
  - ser_out after accept: 0 for 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then 1 for 4 cycles.
  - tx_done pulses at cycle 41 after accept; busy high for 40 cycles.
- BIT_DIV=1, send 0x3C back-to-back with 0xFF (tx_valid held high):
  - ser_out = 0,0,0,1,1,1,1,0,0,1, then idle 1 for one cycle, then 0,1×8,1.
  - Second accept coincides with tx_done.
- tx_valid pulsed with 0x00 during a frame of 0x81: ignored; the 0x81 frame is unaltered; tx_ready=0 throughout.
- rst_n low during data bit 3 of 0xF0:
  - ser_out=1 and busy=0 immediately.
  - After release, 0x55 is sent as a complete correct frame.
- Hold check, BIT_DIV=8: sr_load=1 for 7 of every 8 DATA cycles, and sr_q is stable across each bit window.
